// File: rtl/regfile_pkg.sv
// regfile_pkg: shared clear-FSM state type and default register-file dimensions.
package regfile_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} clr_state_t;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
endpackage

// File: rtl/regfile_clr_fsm.sv
// regfile_clr_fsm: walks an index over every register, one per cycle, to zero the array.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] idx,
  output logic              clr_we
);
  clr_state_t state, state_nxt;
  logic [ADDR_W-1:0] idx_nxt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end
  // The last index moves to DONE, so the counter's wrap never restarts a sweep.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE:  if (clr_req) begin
        state_nxt = SWEEP;
        idx_nxt   = '0;
      end
      SWEEP: begin
        idx_nxt   = idx + ADDR_W'(1);
        state_nxt = (idx == '1) ? DONE : SWEEP;
      end
      default: state_nxt = IDLE;
    endcase
  end
  assign busy   = state == SWEEP;
  assign done   = state == DONE;
  assign clr_we = busy;
endmodule

// File: rtl/multiport_regfile.sv
// multiport_regfile: 2-write / NUM_RD-read register file with hardwired zero register and clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [ADDR_W-1:0] clr_idx;
  logic              clr_we, wr0, wr1;
  regfile_clr_fsm #(.ADDR_W(ADDR_W)) u_clr (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(clr_busy),
    .done(clr_done), .idx(clr_idx), .clr_we(clr_we)
  );
  assign wr0 = we0 && waddr0 != '0 && !clr_busy;
  assign wr1 = we1 && waddr1 != '0 && !clr_busy;
  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (clr_we) begin
      regs[clr_idx] <= '0;
    end else begin
      if (wr0) regs[waddr0] <= wdata0;
      if (wr1) regs[waddr1] <= wdata1;
    end
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = raddr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    assign rdata[k*DATA_W +: DATA_W] = (wr1 && waddr1 == ra) ? wdata1 :
                                       (wr0 && waddr0 == ra) ? wdata0 : regs[ra];
`else
    assign rdata[k*DATA_W +: DATA_W] = regs[ra];
`endif
  end
endmodule

// File: tb/tb_multiport_regfile.sv
// tb_multiport_regfile: randomized self-checking bench against an array model of the register file.
module tb_multiport_regfile;
  localparam int DW = 32, AW = 5, NR = 2, DEPTH = 32;
  logic clk = 0, rst = 0;
  logic we0 = 0, we1 = 0, clr_req = 0;
  logic [AW-1:0] waddr0 = 0, waddr1 = 0;
  logic [DW-1:0] wdata0 = 0, wdata1 = 0;
  logic [NR*AW-1:0] raddr = 0;
  logic [NR*DW-1:0] rdata;
  logic clr_busy, clr_done;
  logic [DW-1:0] model [DEPTH];
  int passed = 0, total = 0;

  multiport_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst(rst), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .raddr(raddr), .rdata(rdata),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] expect_rd(input logic [AW-1:0] a, input logic busy);
    logic [DW-1:0] v;
    v = model[a];
`ifdef REGFILE_BYPASS_EN
    if (!busy && we0 && waddr0 != 0 && waddr0 == a) v = wdata0;
    if (!busy && we1 && waddr1 != 0 && waddr1 == a) v = wdata1;
`endif
    return v;
  endfunction

  function automatic void model_write();
    if (we0 && waddr0 != 0) model[waddr0] = wdata0;
    if (we1 && waddr1 != 0) model[waddr1] = wdata1;
  endfunction

  task automatic test_reset();
    rst = 0;
    #3;
    total++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0)
      $display("FAIL reset_flags_low busy=%b done=%b expected 0 0", clr_busy, clr_done);
    else passed++;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    tick();
    rst = 1;
    tick();
    for (int a = 0; a < DEPTH; a++) begin
      raddr = {AW'(a), AW'(a)};
      #1;
      total++;
      if (rdata !== '0) $display("FAIL reset_read addr=%0d got %h expected 0", a, rdata);
      else passed++;
    end
    total++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0)
      $display("FAIL reset_flags busy=%b done=%b expected 0 0", clr_busy, clr_done);
    else passed++;
  endtask

  task automatic test_write_read();
    we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
    model_write();
    tick();
    we0 = 0;
    raddr = {AW'(0), AW'(5)};
    #1;
    total++;
    if (rdata[DW-1:0] !== 32'hDEADBEEF)
      $display("FAIL write_read got %h expected deadbeef", rdata[DW-1:0]);
    else passed++;
    we0 = 1; waddr0 = 0; wdata0 = 32'h1234;
    model_write();
    tick();
    we0 = 0;
    raddr = {AW'(0), AW'(0)};
    #1;
    total++;
    if (rdata !== '0) $display("FAIL zero_reg got %h expected 0", rdata);
    else passed++;
  endtask

  task automatic test_priority();
    we0 = 1; waddr0 = 7; wdata0 = 32'hAAAA0000;
    we1 = 1; waddr1 = 7; wdata1 = 32'h5555FFFF;
    model_write();
    tick();
    we0 = 0; we1 = 0;
    raddr = {AW'(7), AW'(7)};
    #1;
    total++;
    if (rdata[DW-1:0] !== 32'h5555FFFF || rdata[2*DW-1:DW] !== 32'h5555FFFF)
      $display("FAIL priority got %h expected 5555ffff on both ports", rdata);
    else passed++;
  endtask

  task automatic test_random();
    logic [AW-1:0] r0, r1;
    for (int n = 0; n < 80; n++) begin
      we0 = 1'($urandom); we1 = 1'($urandom);
      waddr0 = AW'($urandom); waddr1 = (n % 5 == 0) ? waddr0 : AW'($urandom);
      wdata0 = $urandom; wdata1 = $urandom;
      r0 = (n % 3 == 0) ? waddr1 : AW'($urandom);
      r1 = (n % 4 == 0) ? waddr0 : AW'($urandom);
      raddr = {r1, r0};
      #1;
      total++;
      if (rdata[DW-1:0] !== expect_rd(r0, 1'b0) || rdata[2*DW-1:DW] !== expect_rd(r1, 1'b0))
        $display("FAIL random_read n=%0d got %h expected %h_%h", n, rdata, expect_rd(r1, 1'b0), expect_rd(r0, 1'b0));
      else passed++;
      model_write();
      tick();
    end
    we0 = 0; we1 = 0;
    for (int a = 0; a < DEPTH; a++) begin
      raddr = {AW'(a), AW'(a)};
      #1;
      total++;
      if (rdata[DW-1:0] !== model[a] || rdata[2*DW-1:DW] !== model[a])
        $display("FAIL random_final addr=%0d got %h expected %h", a, rdata, model[a]);
      else passed++;
    end
  endtask

  task automatic load_all();
    for (int a = 1; a < DEPTH; a++) begin
      we0 = 1; waddr0 = AW'(a); wdata0 = $urandom | 32'h1;
      model_write();
      tick();
    end
    we0 = 0;
  endtask

  task automatic test_clear();
    int busy_cycles = 0, done_pulses = 0;
    load_all();
    clr_req = 1;
    tick();
    clr_req = 0;
    total++;
    if (clr_busy !== 1'b1) $display("FAIL clear_start busy=%b expected 1", clr_busy);
    else passed++;
    while (clr_busy === 1'b1 && busy_cycles < 100) begin
      busy_cycles++;
      if (clr_done === 1'b1) done_pulses++;
      we0 = (busy_cycles == 20); waddr0 = 3; wdata0 = 32'hCAFEF00D;
      tick();
      we0 = 0;
    end
    total++;
    if (busy_cycles != DEPTH) $display("FAIL clear_len got %0d cycles expected %0d", busy_cycles, DEPTH);
    else passed++;
    total++;
    if (clr_done !== 1'b1) $display("FAIL clear_done got %b expected 1", clr_done);
    else passed++;
    tick();
    total++;
    if (clr_done !== 1'b0 || clr_busy !== 1'b0 || done_pulses != 0)
      $display("FAIL clear_after done=%b busy=%b early_pulses=%0d expected 0 0 0", clr_done, clr_busy, done_pulses);
    else passed++;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int a = 0; a < DEPTH; a++) begin
      raddr = {AW'(a), AW'(a)};
      #1;
      total++;
      if (rdata !== '0) $display("FAIL clear_read addr=%0d got %h expected 0", a, rdata);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_sweep();
    load_all();
    clr_req = 1;
    tick();
    clr_req = 0;
    repeat (10) tick();
    rst = 0;
    #1;
    total++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0)
      $display("FAIL abort_flags busy=%b done=%b expected 0 0", clr_busy, clr_done);
    else passed++;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int a = 0; a < DEPTH; a += 3) begin
      raddr = {AW'(DEPTH - 1 - a), AW'(a)};
      #1;
      total++;
      if (rdata !== '0) $display("FAIL abort_read addr=%0d got %h expected 0", a, rdata);
      else passed++;
    end
    tick();
    rst = 1;
    for (int n = 0; n < 4; n++) begin
      tick();
      total++;
      if (clr_busy !== 1'b0 || clr_done !== 1'b0)
        $display("FAIL abort_idle n=%0d busy=%b done=%b expected 0 0", n, clr_busy, clr_done);
      else passed++;
    end
  endtask

  task automatic test_bypass();
    we0 = 1; waddr0 = 3; wdata0 = 32'h11111111;
    model_write();
    tick();
    we0 = 0;
    we1 = 1; waddr1 = 3; wdata1 = 32'h0BADF00D;
    raddr = {AW'(3), AW'(0)};
    #1;
    total++;
`ifdef REGFILE_BYPASS_EN
    if (rdata[2*DW-1:DW] !== 32'h0BADF00D)
      $display("FAIL bypass got %h expected 0badf00d", rdata[2*DW-1:DW]);
    else passed++;
`else
    if (rdata[2*DW-1:DW] !== 32'h11111111)
      $display("FAIL no_bypass got %h expected 11111111", rdata[2*DW-1:DW]);
    else passed++;
`endif
    model_write();
    tick();
    we1 = 0;
    #1;
    total++;
    if (rdata[2*DW-1:DW] !== 32'h0BADF00D)
      $display("FAIL bypass_stored got %h expected 0badf00d", rdata[2*DW-1:DW]);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_priority();
    test_random();
    test_clear();
    test_reset_mid_sweep();
    test_bypass();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 Parameter DATA_W, 32, bit width of each register.
REQ-002 Parameter ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter NUM_RD, 2, number of independent combinational read ports (1..4).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 we0 / waddr0 / wdata0  input  1 / ADDR_W / DATA_W  write port 0 (low priority).
REQ-007 we1 / waddr1 / wdata1  input  1 / ADDR_W / DATA_W  write port 1 (high priority).
REQ-008 raddr  input  NUM_RD*ADDR_W  packed read addresses; port k uses slice k.
REQ-009 rdata  output  NUM_RD*DATA_W  packed read data; port k uses slice k.
REQ-010 clr_req  input  1  request a full-array clear sweep.
REQ-011 clr_busy  output  1  high while the sweep runs.
REQ-012 clr_done  output  1  one-cycle pulse when the sweep completes.

Function
REQ-013 Register 0 SHALL read as zero at all times; writes to address 0 SHALL be discarded.
REQ-014 A write with weN=1 SHALL update register waddrN at the rising edge.
REQ-015 If both ports write the same nonzero address in one cycle, port 1 data SHALL be stored.
REQ-016 Reads SHALL be combinational: rdata slice k = register[raddr slice k], with zero latency.
REQ-017 The clear controller SHALL be a three-state FSM: IDLE, SWEEP, DONE.
REQ-018 IDLE -> SWEEP on clr_req=1; the index counter loads 0.
REQ-019 In SWEEP, one register per cycle (at the index) SHALL be zeroed; the index increments by 1.
REQ-020 SWEEP -> DONE after index DEPTH-1 is cleared; the sweep lasts exactly DEPTH cycles.
REQ-021 DONE SHALL assert clr_done for one cycle, then return to IDLE.
REQ-022 clr_busy SHALL be 1 exactly in SWEEP; clr_done SHALL be 1 exactly in DONE.
REQ-023 clr_req SHALL be ignored outside IDLE; a held clr_req re-triggers only from IDLE.
REQ-024 While clr_busy=1, both write ports SHALL be ignored; reads return current array contents.
REQ-025 The index counter SHALL be ADDR_W bits wide and SHALL NOT wrap back into SWEEP.

Reset
REQ-026 rst=0 SHALL immediately zero all DEPTH registers, force the FSM to IDLE, clear the index, and drive clr_busy=0 and clr_done=0.
REQ-027 Reset asserted mid-sweep SHALL abort the sweep without a clr_done pulse.
REQ-028 After rst deasserts, all rdata slices SHALL read 0 until the first write.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-030 With REGFILE_BYPASS_EN defined: if raddr k matches an active nonzero write address in the same cycle (clr_busy=0), rdata k SHALL return that write data, with port 1 taking priority over port 0.
REQ-031 Without REGFILE_BYPASS_EN: rdata k SHALL return the pre-edge stored value, and there SHALL be no forwarding logic.

Structure
REQ-032 Shared package regfile_pkg SHALL hold the FSM state typedef (IDLE/SWEEP/DONE) and the default DATA_W/ADDR_W/NUM_RD constants.
REQ-033 The clear controller SHALL be the sub-module regfile_clr_fsm, which outputs busy, done, the clear index and the clear-write strobe.
REQ-034 The array, write arbitration and read/bypass muxing SHALL live in multiport_regfile.

Verification
REQ-035 Test 1: rst low, then high -> all NUM_RD ports read 0x00000000; clr_busy=0; clr_done=0.
REQ-036 Test 2: we0=1, waddr0=5, wdata0=0xDEADBEEF; next cycle raddr0=5 -> rdata0=0xDEADBEEF. Then write 0x1234 to address 0 -> read address 0 gives 0.
REQ-037 Test 3: we0 and we1 both write address 7 with 0xAAAA0000 and 0x5555FFFF -> address 7 reads 0x5555FFFF.
REQ-038 Test 4: registers 1..31 loaded nonzero, then pulse clr_req -> clr_busy high for 32 cycles, clr_done pulses once, all reads 0; a we0 write issued during the sweep is lost.
REQ-039 Test 5: reset asserted at sweep cycle 10 -> clr_busy drops immediately, no clr_done pulse, array reads zero.
REQ-040 Test 6 (REGFILE_BYPASS_EN defined): we1 writes 0x0BADF00D to address 3 while raddr1=3 in the same cycle -> rdata1=0x0BADF00D in that cycle. Without the macro, the old value is returned.
